alu_seq: RTL and testbench

Parametrised, multi-cycle successor to the datapath ALU. It keeps the existing 4-bit opcode set and adds signed compare, arithmetic shift, and iterative multiply/divide. It sits in the execute stage behind a valid/ready handshake, so the pipeline can stall on long operations. Results and flags are registered and held until the consumer accepts them.

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_seq_muldiv_iter.sv | 94 +++++++++
 rtl/alu_seq.sv | 201 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the multi-cycle execute-stage ALU.
// Holds the 4-bit opcode map, the handshake FSM state type and the
// flag bundle that travels with each result.
// Related build macro: ALU_SEQ_MULDIV_EN (see alu_seq.sv).
package alu_seq_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;
  localparam logic [3:0] OP_MULU = 4'b1010;
  localparam logic [3:0] OP_DIVU = 4'b1011;
  localparam logic [3:0] OP_SRA  = 4'b1100;
  localparam logic [3:0] OP_SLT  = 4'b1101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic divz;
    logic illegal;
  } alu_flags_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv_iter.sv
// muldiv_iter
// Iterative unsigned multiply (shift-add) and restoring divide, one bit
// per clock. i_start loads the operands; WIDTH steps follow and o_done
// is high during the last one. o_lo/o_hi present the value the
// accumulator takes at the next edge, so when o_done is high they are
// the final product (lo/hi halves) or quotient/remainder.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   i_start           load operands and begin (ignored while busy)
//   i_op              0 = multiply, 1 = divide
//   i_a, i_b          multiplicand/dividend, multiplier/divisor
//   o_done            final step in progress this cycle
//   o_lo, o_hi        result halves (product lo/hi, quotient/remainder)
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_b;
  logic             r_div;
  logic             r_busy;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_lo_nxt;
  logic [WIDTH-1:0] w_hi_nxt;

  always_comb begin
    w_add    = '0;
    w_trial  = '0;
    w_lo_nxt = r_lo;
    w_hi_nxt = r_hi;
    if (r_div) begin
      // Partial remainder stays below the divisor, so the shifted value
      // fits WIDTH+1 bits and the trial MSB is a clean borrow indicator.
      w_trial = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};
      if (!w_trial[WIDTH]) begin
        w_hi_nxt = w_trial[WIDTH-1:0];
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
        w_lo_nxt = {r_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      // Multiplier sits in r_lo and shifts out as product bits shift in.
      w_add = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      {w_hi_nxt, w_lo_nxt} = {w_add, r_lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lo   <= '0;
      r_hi   <= '0;
      r_b    <= '0;
      r_div  <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (i_start && !r_busy) begin
      r_lo   <= i_a;
      r_hi   <= '0;
      r_b    <= i_b;
      r_div  <= i_op;
      r_busy <= 1'b1;
      r_cnt  <= CW'(WIDTH - 1);
    end else if (r_busy) begin
      r_lo <= w_lo_nxt;
      r_hi <= w_hi_nxt;
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_done = r_busy && (r_cnt == '0);
  assign o_lo   = w_lo_nxt;
  assign o_hi   = w_hi_nxt;

endmodule

// File: rtl/alu_seq.sv
// alu_seq
// Multi-cycle execute-stage ALU behind valid/ready handshakes. Single-
// cycle ops are computed from the inputs and registered at acceptance;
// mulu/divu run in muldiv_iter. Results and flags are held in DONE
// until the consumer takes them.
// Build macro: ALU_SEQ_MULDIV_EN enables mulu/divu; without it those
// opcodes decode as illegal and OUT_HI is tied to 0.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operation handshake (ready only in IDLE)
//   In1, In2, ALUOP       operands and opcode, captured at acceptance
//   out_valid / out_ready result handshake
//   OUT, OUT_HI           result / product high or remainder
//   ZeroFlag, Overflow, DivZero, Illegal   result flags
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// BUSY  | iterative mulu/divu in progress
// DONE  | result held, out_valid high until out_ready
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] In1,
  input  logic [WIDTH-1:0] In2,
  input  logic [3:0]       ALUOP,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] OUT,
  output logic [WIDTH-1:0] OUT_HI,
  output logic             ZeroFlag,
  output logic             Overflow,
  output logic             DivZero,
  output logic             Illegal
);

  alu_state_t       r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out;
  alu_flags_t       r_flags;

  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_res;
  alu_flags_t       w_flg;
  logic             w_is_branch;
  logic             w_md_start;

`ifdef ALU_SEQ_MULDIV_EN
  logic [WIDTH-1:0] r_out_hi;
  logic [WIDTH-1:0] w_res_hi;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_lo;
  logic [WIDTH-1:0] w_md_hi;
`endif

  assign w_sh = In2[SHW-1:0];

  // Single-cycle result, also the immediate divide-by-zero result.
  always_comb begin
    w_res       = '0;
    w_flg       = '0;
    w_is_branch = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    w_res_hi    = '0;
`endif
    case (ALUOP)
      OP_ADD: begin
        w_res     = In1 + In2;
        w_flg.ovf = (In1[WIDTH-1] == In2[WIDTH-1]) && (w_res[WIDTH-1] != In1[WIDTH-1]);
      end
      OP_SUB: begin
        w_res     = In1 - In2;
        w_flg.ovf = (In1[WIDTH-1] != In2[WIDTH-1]) && (w_res[WIDTH-1] != In1[WIDTH-1]);
      end
      OP_AND:  w_res = In1 & In2;
      OP_OR:   w_res = In1 | In2;
      OP_SLL:  w_res = In1 << w_sh;
      OP_SRL:  w_res = In1 >> w_sh;
      OP_SRA:  w_res = $signed(In1) >>> w_sh;
      OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (In1 < In2)};
      OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(In1) < $signed(In2))};
      OP_BEQ: begin
        w_is_branch = 1'b1;
        w_flg.zero  = (In1 == In2);
      end
      OP_BNE: begin
        w_is_branch = 1'b1;
        w_flg.zero  = (In1 != In2);
      end
`ifdef ALU_SEQ_MULDIV_EN
      OP_DIVU: begin
        w_res      = '1;
        w_res_hi   = In1;
        w_flg.divz = 1'b1;
      end
`endif
      default: w_flg.illegal = 1'b1;
    endcase
    if (!w_is_branch) begin
      w_flg.zero = (w_res == '0);
    end
  end

`ifdef ALU_SEQ_MULDIV_EN
  // Divide by zero never enters BUSY; it completes like a single-cycle op.
  assign w_md_start = (r_state == IDLE) && in_valid && is_muldiv(ALUOP) &&
                      !((ALUOP == OP_DIVU) && (In2 == '0));

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_md_start),
    .i_op    (ALUOP == OP_DIVU),
    .i_a     (In1),
    .i_b     (In2),
    .o_done  (w_md_done),
    .o_lo    (w_md_lo),
    .o_hi    (w_md_hi)
  );
`else
  assign w_md_start = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_flags     <= '0;
`ifdef ALU_SEQ_MULDIV_EN
      r_out_hi    <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (w_md_start) begin
              r_state <= BUSY;
            end else begin
              r_state     <= DONE;
              r_out_valid <= 1'b1;
              r_out       <= w_res;
              r_flags     <= w_flg;
`ifdef ALU_SEQ_MULDIV_EN
              r_out_hi    <= w_res_hi;
`endif
            end
          end
        end
`ifdef ALU_SEQ_MULDIV_EN
        BUSY: begin
          if (w_md_done) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out       <= w_md_lo;
            r_out_hi    <= w_md_hi;
            r_flags     <= '{zero: (w_md_lo == '0), ovf: 1'b0, divz: 1'b0, illegal: 1'b0};
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign OUT       = r_out;
  assign ZeroFlag  = r_flags.zero;
  assign Overflow  = r_flags.ovf;
  assign DivZero   = r_flags.divz;
  assign Illegal   = r_flags.illegal;
`ifdef ALU_SEQ_MULDIV_EN
  assign OUT_HI    = r_out_hi;
`else
  assign OUT_HI    = '0;
`endif

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  localparam int W = 32;
`ifdef ALU_SEQ_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  In1 = '0;
  logic [W-1:0]  In2 = '0;
  logic [3:0]    ALUOP = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  OUT;
  logic [W-1:0]  OUT_HI;
  logic          ZeroFlag, Overflow, DivZero, Illegal;

  int n_chk = 0;
  int n_err = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .In1       (In1),
    .In2       (In2),
    .ALUOP     (ALUOP),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .OUT       (OUT),
    .OUT_HI    (OUT_HI),
    .ZeroFlag  (ZeroFlag),
    .Overflow  (Overflow),
    .DivZero   (DivZero),
    .Illegal   (Illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] out;
    logic [W-1:0] hi;
    bit           z;
    bit           ov;
    bit           dz;
    bit           il;
    int           lat;
  } exp_t;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour from the opcode table, in plain integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int sa, sb;
    longint s;
    longint unsigned p;
    logic [63:0] pv;
    bit branch;
    sa = a; sb = b;
    e.out = '0; e.hi = '0; e.z = 0; e.ov = 0; e.dz = 0; e.il = 0; e.lat = 1;
    branch = 0;
    case (op)
      4'd2:  begin e.out = a + b; s = longint'(sa) + longint'(sb); e.ov = (s != longint'(int'(s))); end
      4'd6:  begin e.out = a - b; s = longint'(sa) - longint'(sb); e.ov = (s != longint'(int'(s))); end
      4'd0:  e.out = a & b;
      4'd1:  e.out = a | b;
      4'd4:  e.out = a << b[4:0];
      4'd5:  e.out = a >> b[4:0];
      4'd12: e.out = sa >>> b[4:0];
      4'd7:  e.out = (a < b) ? 1 : 0;
      4'd13: e.out = (sa < sb) ? 1 : 0;
      4'd8:  begin branch = 1; e.z = (a == b); end
      4'd9:  begin branch = 1; e.z = (a != b); end
      4'd10: if (MD) begin
               p = {32'b0, a} * {32'b0, b};
               pv = p;
               e.out = pv[31:0]; e.hi = pv[63:32]; e.lat = W + 1;
             end else e.il = 1;
      4'd11: if (MD) begin
               if (b == 0) begin e.out = '1; e.hi = a; e.dz = 1; end
               else begin e.out = a / b; e.hi = a % b; e.lat = W + 1; end
             end else e.il = 1;
      default: e.il = 1;
    endcase
    if (!branch) e.z = (e.out == 0);
    return e;
  endfunction

  task automatic chk_outs(input string tag, input exp_t e);
    chk({tag, ".out"}, OUT, e.out);
    chk({tag, ".hi"}, OUT_HI, e.hi);
    chk({tag, ".flags"}, {ZeroFlag, Overflow, DivZero, Illegal}, {e.z, e.ov, e.dz, e.il});
  endtask

  // Called at a negedge in IDLE; returns at a negedge back in IDLE.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    exp_t e;
    int lat;
    e = model(op, a, b);
    chk({tag, ".rdy"}, in_ready, 1);
    In1 = a; In2 = b; ALUOP = op; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    In1 = $urandom; In2 = $urandom; ALUOP = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 3 * W) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, lat, e.lat);
    chk_outs(tag, e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_v"}, {out_valid, in_ready}, 2'b10);
      chk_outs({tag, ".hold"}, e);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".rel"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    logic [3:0]   op;
    logic [W-1:0] a, b;
    bit           seen;

    repeat (3) @(negedge clk);
    chk("rst.hs", {out_valid, in_ready}, 2'b01);
    chk_outs("rst", '{out: 0, hi: 0, z: 0, ov: 0, dz: 0, il: 0, lat: 0});
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 0);
    run_op("sra",     4'b1100, 32'hF000_0000, 32'h24, 1);
    run_op("slt",     4'b1101, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("sltu",    4'b0111, 32'hFFFF_FFFF, 32'h1, 0);
    run_op("beq",     4'b1000, 32'd5, 32'd5, 0);
    run_op("bne",     4'b1001, 32'd5, 32'd5, 0);
    run_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1, 0);
    run_op("illegal", 4'b0011, 32'h1234, 32'h5678, 2);
    run_op("mulu",    4'b1010, 32'hFFFF_FFFF, 32'd2, 5);
    run_op("divu",    4'b1011, 32'd100, 32'd7, 1);
    run_op("divu0",   4'b1011, 32'd9, 32'd0, 0);

    // Reset 10 cycles into a mulu: result must never appear.
    In1 = 32'd3; In2 = 32'd5; ALUOP = 4'b1010; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort.hs", {out_valid, in_ready}, 2'b01);
    chk_outs("abort", '{out: 0, hi: 0, z: 0, ov: 0, dz: 0, il: 0, lat: 0});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (W + 8) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("abort.stale", seen, 0);

    for (int k = 0; k < 40; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = $urandom_range(1, 300);
        2: b = a;
        default: b = $urandom;
      endcase
      run_op($sformatf("rnd%0d_op%0d", k, op), op, a, b, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
